// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single MMU access path between the CPU
// instruction-fetch port (IF) and data port (DM), with a fixed hold window.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_byte,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mmu_if_read,
  output logic        mmu_if_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_input_data,
  output logic        mmu_bytemode,
  input  logic [31:0] mmu_output_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        last_grant;  // 0 = IF, 1 = DM
  logic        grant;
  logic        grant_nx;
  logic        misaligned;
  logic        we_q;
  logic        err_q;
  logic [3:0]  cnt;

  // Handshake: a port holds req and its fields stable until its one-cycle
  // ack; an ack with err set means the access never reached the MMU.
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_nx   = (if_req && dm_req) ? ~last_grant : dm_req;
          misaligned = grant_nx ? ((dm_addr[1:0] != 2'b00) && !dm_byte)
                                : (if_addr[1:0] != 2'b00);
          state_nx   = misaligned ? DONE : ACCESS;
        end
      end
      ACCESS:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mmu_if_read  = (state == ACCESS) && !we_q;
  assign mmu_if_write = (state == ACCESS) && we_q;
  assign if_ack       = (state == DONE) && !grant;
  assign dm_ack       = (state == DONE) && grant;
  assign if_err       = if_ack && err_q;
  assign dm_err       = dm_ack && err_q;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b0;
      grant          <= 1'b0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      cnt            <= 4'd0;
      mmu_addr       <= 32'd0;
      mmu_input_data <= 32'd0;
      mmu_bytemode   <= 1'b0;
      if_rdata       <= 32'd0;
      dm_rdata       <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        grant      <= grant_nx;
        last_grant <= grant_nx;
        err_q      <= misaligned;
        // A rejected access leaves the MMU address/data lines untouched.
        if (!misaligned) begin
          we_q         <= grant_nx && dm_we;
          mmu_addr     <= grant_nx ? dm_addr : if_addr;
          mmu_bytemode <= grant_nx && dm_byte;
          if (grant_nx)
            mmu_input_data <= dm_byte ? {24'd0, dm_wdata[7:0]} : dm_wdata;
          cnt          <= 4'(WAIT_CYCLES - 1);
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0 && !we_q) begin
          if (grant) dm_rdata <= mmu_output_data;
          else       if_rdata <= mmu_output_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario and checks
// the cycle-accurate MMU strobes, acks and returned data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        dm_byte = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mmu_if_read;
  logic        mmu_if_write;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_input_data;
  logic        mmu_bytemode;
  logic [31:0] mmu_output_data = 32'd0;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mmu_if_read(mmu_if_read), .mmu_if_write(mmu_if_write),
    .mmu_addr(mmu_addr), .mmu_input_data(mmu_input_data),
    .mmu_bytemode(mmu_bytemode), .mmu_output_data(mmu_output_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Advance one cycle; sampling and driving happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({if_ack, if_err, dm_ack, dm_err, mmu_if_read, mmu_if_write, mmu_bytemode} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000000",
               {if_ack, if_err, dm_ack, dm_err, mmu_if_read, mmu_if_write, mmu_bytemode});
    end
    vectors++;
    if ({mmu_addr, mmu_input_data} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mmu_bus: got %h %h want 0", mmu_addr, mmu_input_data);
    end
    vectors++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h %h want 0", if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    vectors++;
    if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ack: got %b%b want 00", if_ack, dm_ack);
    end
    tick();
  endtask

  task automatic test_single_read();
    if_req = 1'b1; if_addr = 32'h8000_0004; mmu_output_data = 32'h2421_F000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (mmu_if_read !== (c <= 2) || mmu_if_write !== 1'b0) begin
        miscompares++;
        $display("FAIL read_strobe c%0d: got rd=%b wr=%b want rd=%b wr=0", c, mmu_if_read, mmu_if_write, c <= 2);
      end
      if (c <= 2) begin
        vectors++;
        if (mmu_addr !== 32'h8000_0004 || mmu_bytemode !== 1'b0) begin
          miscompares++;
          $display("FAIL read_addr c%0d: got %h bm=%b want 80000004 bm=0", c, mmu_addr, mmu_bytemode);
        end
      end
      vectors++;
      if (if_ack !== (c == 3) || dm_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL read_ack c%0d: got if=%b dm=%b want if=%b dm=0", c, if_ack, dm_ack, c == 3);
      end
    end
    vectors++;
    if (if_rdata !== 32'h2421_F000 || if_err !== 1'b0) begin
      miscompares++;
      $display("FAIL read_data: got %h err=%b want 2421f000 err=0", if_rdata, if_err);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h2421_F000) begin
      miscompares++;
      $display("FAIL read_hold: got ack=%b data=%h want ack=0 data=2421f000", if_ack, if_rdata);
    end
  endtask

  task automatic test_byte_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1;
    dm_addr = 32'h8000_0007; dm_wdata = 32'h0000_00AB; mmu_output_data = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (mmu_if_write !== (c <= 2) || mmu_if_read !== 1'b0) begin
        miscompares++;
        $display("FAIL write_strobe c%0d: got wr=%b rd=%b want wr=%b rd=0", c, mmu_if_write, mmu_if_read, c <= 2);
      end
      if (c <= 2) begin
        vectors++;
        if (mmu_bytemode !== 1'b1 || mmu_addr !== 32'h8000_0007 || mmu_input_data !== 32'h0000_00AB) begin
          miscompares++;
          $display("FAIL write_bus c%0d: got bm=%b a=%h d=%h want 1 80000007 000000ab", c, mmu_bytemode, mmu_addr, mmu_input_data);
        end
      end
      vectors++;
      if (dm_ack !== (c == 3) || if_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL write_ack c%0d: got dm=%b if=%b want dm=%b if=0", c, dm_ack, if_ack, c == 3);
      end
    end
    vectors++;
    if (dm_rdata !== 32'd0 || dm_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_rdata: got %h err=%b want 00000000 err=0", dm_rdata, dm_err);
    end
    dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h8000_0002;
    tick();
    vectors++;
    if (dm_ack !== 1'b1 || dm_err !== 1'b1 || mmu_if_read !== 1'b0 || mmu_if_write !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_ack: got ack=%b err=%b rd=%b wr=%b want 1 1 0 0", dm_ack, dm_err, mmu_if_read, mmu_if_write);
    end
    vectors++;
    if (mmu_addr !== 32'h8000_0007) begin
      miscompares++;
      $display("FAIL misaligned_addr: got %h want 80000007", mmu_addr);
    end
    dm_req = 1'b0;
    tick();
    vectors++;
    if (dm_ack !== 1'b0 || dm_err !== 1'b0 || mmu_if_read !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_after: got ack=%b err=%b rd=%b want 0 0 0", dm_ack, dm_err, mmu_if_read);
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h8000_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h8000_0200;
    mmu_output_data = 32'h1111_2222;
    for (int c = 1; c <= 16; c++) begin
      tick();
      vectors++;
      if (dm_ack !== (c == 3 || c == 11) || if_ack !== (c == 7 || c == 15)) begin
        miscompares++;
        $display("FAIL contention_ack c%0d: got if=%b dm=%b want if=%b dm=%b", c, if_ack, dm_ack, c == 7 || c == 15, c == 3 || c == 11);
      end
      if (c == 1 || c == 5) begin
        vectors++;
        if (mmu_addr !== ((c == 1) ? 32'h8000_0200 : 32'h8000_0100)) begin
          miscompares++;
          $display("FAIL contention_grant c%0d: got %h want %h", c, mmu_addr, (c == 1) ? 32'h8000_0200 : 32'h8000_0100);
        end
      end
    end
    vectors++;
    if (dm_rdata !== 32'h1111_2222 || if_rdata !== 32'h1111_2222) begin
      miscompares++;
      $display("FAIL contention_data: got if=%h dm=%h want 11112222", if_rdata, dm_rdata);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    if_req = 1'b1; if_addr = 32'h8000_0300;
    dm_req = 1'b1; dm_addr = 32'h8000_0400;
    tick();
    vectors++;
    if (mmu_if_read !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_access: got rd=%b want 1", mmu_if_read);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({if_ack, if_err, dm_ack, dm_err, mmu_if_read, mmu_if_write, mmu_bytemode} !== 7'd0 ||
        {mmu_addr, mmu_input_data, if_rdata, dm_rdata} !== 128'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got flags=%b addr=%h wd=%h ird=%h drd=%h want all 0",
               {if_ack, if_err, dm_ack, dm_err, mmu_if_read, mmu_if_write, mmu_bytemode},
               mmu_addr, mmu_input_data, if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        vectors++;
        if (mmu_addr !== 32'h8000_0400 || mmu_if_read !== 1'b1) begin
          miscompares++;
          $display("FAIL midrst_regrant: got %h rd=%b want 80000400 rd=1", mmu_addr, mmu_if_read);
        end
      end
      vectors++;
      if (dm_ack !== (c == 3) || if_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_ack c%0d: got dm=%b if=%b want dm=%b if=0", c, dm_ack, if_ack, c == 3);
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  task automatic test_field_change();
    if_req = 1'b1; if_addr = 32'h8000_0020;
    tick();
    if_addr = 32'h8000_0010;
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if (mmu_addr !== 32'h8000_0020 || mmu_if_read !== 1'b1) begin
        miscompares++;
        $display("FAIL field_change c%0d: got %h rd=%b want 80000020 rd=1", c, mmu_addr, mmu_if_read);
      end
      tick();
    end
    vectors++;
    if (if_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL field_change_ack: got %b want 1", if_ack);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h8000_0040; mmu_output_data = 32'hAAAA_0001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 4) mmu_output_data = 32'hBBBB_0002;
      vectors++;
      if (if_ack !== (c == 3 || c == 7) || mmu_if_read !== (c == 1 || c == 2 || c == 5 || c == 6)) begin
        miscompares++;
        $display("FAIL b2b c%0d: got ack=%b rd=%b want ack=%b rd=%b", c, if_ack, mmu_if_read,
                 c == 3 || c == 7, c == 1 || c == 2 || c == 5 || c == 6);
      end
      if (c == 3 || c == 7) begin
        vectors++;
        if (if_rdata !== ((c == 3) ? 32'hAAAA_0001 : 32'hBBBB_0002)) begin
          miscompares++;
          $display("FAIL b2b_data c%0d: got %h want %h", c, if_rdata, (c == 3) ? 32'hAAAA_0001 : 32'hBBBB_0002);
        end
      end
    end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_byte_write();
    test_misaligned();
    test_contention();
    test_reset_mid_access();
    test_field_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single SRAM/UART memory access path (the MMU) between the CPU's instruction-fetch port (IF) and data port (DM). Holds each granted access stable on the MMU request lines for a fixed number of cycles, captures the read result, and returns a one-cycle acknowledge. Arbitrates contended requests round-robin. Rejects misaligned word accesses without touching memory.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles an access is held on the MMU lines (1..15).
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active-low.
- `if_req` in 1: fetch request. Held with its fields until `if_ack`.
- `if_addr` in 32: fetch byte address.
- `if_ack` out 1: one-cycle pulse when the fetch completes.
- `if_rdata` out 32: fetched word, valid while `if_ack` is high, held until the next IF completion.
- `if_err` out 1: qualifies `if_ack`. Set for a misaligned fetch.
- `dm_req` in 1: data request. Held with its fields until `dm_ack`.
- `dm_we` in 1: 1 for write, 0 for read.
- `dm_byte` in 1: byte access (lb/sb).
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: write data. For byte writes, bits [7:0] are used.
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_rdata` out 32: read data, valid with `dm_ack`, held until the next DM completion.
- `dm_err` out 1: qualifies `dm_ack`. Set for a misaligned word access.
- `mmu_if_read` out 1: MMU read strobe.
- `mmu_if_write` out 1: MMU write strobe.
- `mmu_addr` out 32: MMU address.
- `mmu_input_data` out 32: MMU write data.
- `mmu_bytemode` out 1: MMU byte mode.
- `mmu_output_data` in 32: MMU read data.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **Reset:**
  - State IDLE; `last_grant` = IF.
  - All outputs 0, including `mmu_*` strobes, address, data, bytemode, both `*_rdata` and both `*_err`.
- **IDLE:** evaluate `if_req`/`dm_req` at the edge.
  - Only one request: grant it.
  - Both requests: grant the port that is not `last_grant`. After reset, DM wins the first contention.
  - Latch the granted port's fields into internal registers; update `last_grant`.
- **Misalignment check** (at grant):
  - A word access is misaligned when `addr[1:0]` != 0 and byte = 0. IF accesses are always word accesses.
  - Misaligned grant: go directly to DONE with err = 1. MMU strobes stay 0.
  - Otherwise load the counter with `WAIT_CYCLES`-1 and go to ACCESS.
- **ACCESS:**
  - Drive `mmu_*` from the latched registers. `mmu_if_read` = ~we, `mmu_if_write` = we; for IF, we = 0 and bytemode = 0.
  - Decrement the counter each cycle.
  - At the edge where the counter = 0, capture `mmu_output_data` into the granted port's rdata (reads only) and go to DONE.
- **DONE:**
  - Granted port's ack = 1 for exactly this cycle; err is valid.
  - All `mmu_if_read`/`mmu_if_write` = 0; address and data hold their last values.
  - Next state is IDLE unconditionally.
- **Write rdata:** writes leave that port's rdata unchanged.
- **Ungranted port:** its request is ignored, and its ack stays 0, until a later IDLE evaluation.
- **Request changes mid-access:** changes to `*_req` or fields during ACCESS/DONE are ignored; the latched copies are used.
- **Reset mid-operation:**
  - The access is abandoned; no ack is produced.
  - MMU strobes drop in the cycle after the reset edge.
  - `last_grant` returns to IF.

## Timing
- **Access latency:** request high in IDLE at cycle 0 → ACCESS in cycles 1..`WAIT_CYCLES` → ack in cycle `WAIT_CYCLES`+1.
- **Misaligned latency:** ack in cycle 1.
- **MMU strobe window:** high for exactly `WAIT_CYCLES` consecutive cycles, with the address stable for the whole window. This covers the MMU gating on clk-high.
- **Back-to-back requests:** a requester keeping req high through its ack cycle issues a new request, which is evaluated in the following IDLE cycle. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- **Req during DONE:** req asserted in the DONE cycle by either port is not sampled until IDLE.
- **Ack exclusivity:** `if_ack` and `dm_ack` are never high together.
- **Acks after reset:** there is never an ack in the first cycle after reset release.

## Test plan
- **Single read:** `WAIT_CYCLES`=2; `if_req`, `if_addr`=0x80000004; MMU model returns 0x2421F000.
  - `mmu_if_read`=1 in cycles 1–2 with `mmu_addr`=0x80000004.
  - `if_ack`=1 in cycle 3; `if_rdata`=0x2421F000; `if_err`=0.
- **Byte write:** `dm_req`, `dm_we`=1, `dm_byte`=1, `dm_addr`=0x80000007, `dm_wdata`=0xAB.
  - `mmu_if_write`=1 and `mmu_bytemode`=1 for 2 cycles.
  - `dm_ack` in cycle 3; `dm_rdata` unchanged.
- **Contention:** `if_req` and `dm_req` asserted together from reset and held through repeated acks.
  - Grants alternate DM, IF, DM, IF.
  - Acks arrive every 4 cycles and never overlap.
- **Misaligned word:** `dm_req`, `dm_byte`=0, `dm_addr`=0x80000002.
  - `dm_ack`=1 and `dm_err`=1 in cycle 1.
  - `mmu_if_read` never asserted.
- **Reset mid-ACCESS:** `rst_n`=0 during the first ACCESS cycle.
  - Next cycle: all outputs 0 and no ack.
  - After release, the next contention is granted to DM.
- **Field change mid-access:** change `if_addr` to 0x80000010 during ACCESS.
  - `mmu_addr` stays at the latched value for the whole window.
